// File: rtl/out_arb.sv
// out_arb: output-channel arbiter for one physical router output.
// Grants one of five input ports, holds the grant until the packet tail
// (or until the winner drops its request), and tracks downstream credits.
// Optional macro OARB_RR_EN selects round-robin arbitration; when it is
// undefined, arbitration is fixed priority with the lowest index winning.
module out_arb #(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int BUFDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic [4:0] req,
  input  logic [4:0] send,
  input  logic [4:0] tail,
  input  logic       crd_in,
  output logic [4:0] grt,
  output logic [2:0] sel,
  output logic [2:0] crd_cnt,
  output logic       crd_avail,
  output logic       err
);

  localparam logic [2:0] DEPTH  = 3'(BUFDEPTH);
  localparam logic [2:0] NO_SEL = 3'd7;

  // The credit counter is three bits wide, so depth must fit in 1..7.
  if (BUFDEPTH < 1 || BUFDEPTH > 7) begin : g_bad_depth
    $error("out_arb: BUFDEPTH must be in 1..7");
  end

  // Identifiers are tracing labels only and must be non-negative.
  if (ROUTERID < 0 || PCHID < 0) begin : g_bad_id
    $error("out_arb: ROUTERID and PCHID must be non-negative");
  end

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t     state;
  logic       locked;
  logic       win_req;
  logic       win_send;
  logic       win_tail;
  logic       xfer;
  logic       rel;
  logic       stray;
  logic       starved;
  logic       at_full;
  logic       overflow;
  logic [2:0] pick_idx;
  logic [4:0] pick_oh;

`ifdef OARB_RR_EN
  logic [2:0] rr_ptr;
`endif

  // In LOCK the grant vector is one-hot on the winner, so masking with it
  // picks out the winner's request, send and tail without indexing by sel.
  assign locked    = (state == LOCK);
  assign win_req   = |(req & grt);
  assign win_send  = |(send & grt);
  assign win_tail  = |(tail & grt);
  assign crd_avail = (crd_cnt != 3'd0);

  // A flit only moves when the winner sends and a credit is available.
  assign xfer     = locked & win_send & crd_avail;
  assign rel      = locked & ((xfer & win_tail) | ~win_req);
  assign stray    = |(send & ~grt);
  assign starved  = locked & win_send & ~crd_avail;
  assign at_full  = (crd_cnt == DEPTH);
  assign overflow = crd_in & ~xfer & at_full;

  // Winner search: walk candidates from highest search distance down so the
  // closest requesting port to the search start is the last one written.
  always_comb begin
    logic [2:0] cand;
    cand     = 3'd0;
    pick_idx = 3'd0;
    for (int k = 4; k >= 0; k--) begin
`ifdef OARB_RR_EN
      cand = (rr_ptr >= 3'(5 - k)) ? (rr_ptr - 3'(5 - k)) : (rr_ptr + 3'(k));
`else
      cand = 3'(k);
`endif
      if (req[cand]) begin
        pick_idx = cand;
      end
    end
    pick_oh = 5'(5'd1 << pick_idx);
  end

  // Arbitration FSM: grant on the edge after a request, hold until release,
  // and always pass through IDLE between two grants.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state  <= IDLE;
      grt    <= 5'd0;
      sel    <= NO_SEL;
`ifdef OARB_RR_EN
      rr_ptr <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= LOCK;
            grt   <= pick_oh;
            sel   <= pick_idx;
          end else begin
            grt   <= 5'd0;
            sel   <= NO_SEL;
          end
        end
        LOCK: begin
          if (rel) begin
            state  <= IDLE;
            grt    <= 5'd0;
            sel    <= NO_SEL;
`ifdef OARB_RR_EN
            rr_ptr <= (sel == 3'd4) ? 3'd0 : (sel + 3'd1);
`endif
          end
        end
        default: begin
          state <= IDLE;
          grt   <= 5'd0;
          sel   <= NO_SEL;
        end
      endcase
    end
  end

  // Credit tracking and sticky protocol error: a transfer and a returning
  // credit cancel, overflowing credits are dropped, and misuse sets err.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      crd_cnt <= DEPTH;
      err     <= 1'b0;
    end else begin
      if (xfer && !crd_in) begin
        crd_cnt <= crd_cnt - 3'd1;
      end else if (crd_in && !xfer && !at_full) begin
        crd_cnt <= crd_cnt + 3'd1;
      end
      if (stray || starved || overflow) begin
        err <= 1'b1;
      end
    end
  end

endmodule
